// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and default geometry for the ram and its arbiter.
package ram_pkg;
  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_e;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 5;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr with wrap.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o
);
  logic [2*NREQ-1:0] rot_w, back_w;
  logic [NREQ-1:0] rot, pick;
  // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
  assign rot_w  = {req_i, req_i} >> ptr_i;
  assign rot    = rot_w[NREQ-1:0];
  assign pick   = rot & (-rot);
  assign back_w = {pick, pick} << ptr_i;
  assign gnt_o  = back_w[2*NREQ-1:NREQ];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one ram between NREQ requesters, with atomic lock
// and idle-timeout revocation; responses are routed back by a registered one-hot tag.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int LOCK_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  we_i,
  input  logic [NREQ-1:0]  lock_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [NREQ-1:0]  rvalid_o,
  output logic [DW-1:0]    rdata_o,
  output logic             lock_err_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic             ram_we_o,
  output logic [DW-1:0]    ram_din_o,
  input  logic [DW-1:0]    ram_dout_i
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX + 1);
  state_e state_q, state_d;
  logic [PW-1:0] rr_q, rr_d, owner_q, owner_d, win;
  logic [CW-1:0] idle_q, idle_d;
  logic [NREQ-1:0] rvalid_q, pick, own_oh, gnt;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic timeout;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] v);
    return (v == PW'(NREQ - 1)) ? '0 : v + PW'(1);
  endfunction
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (.req_i(req_i), .ptr_i(rr_q), .gnt_o(pick));
  always_comb begin
    own_oh  = NREQ'(1) << owner_q;
    timeout = (state_q == ST_LOCKED) && !(|(req_i & own_oh)) && (idle_q == CW'(LOCK_MAX - 1));
    gnt     = !rst_n ? '0 : (state_q == ST_LOCKED) ? (req_i & own_oh) : pick;
    win     = '0;
    addr_d  = addr_q;
    din_d   = din_q;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        win    = PW'(i);
        addr_d = addr_i[i*AW +: AW];
        din_d  = wdata_i[i*DW +: DW];
      end
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    idle_d  = idle_q;
    // while locked rr already equals owner+1, so advancing it on every grant is safe
    if (|gnt) begin
      idle_d  = '0;
      rr_d    = nxt(win);
      owner_d = win;
      state_d = (|(gnt & lock_i)) ? ST_LOCKED : ST_UNLOCKED;
    end else if (timeout) begin
      idle_d  = '0;
      rr_d    = nxt(owner_q);
      state_d = ST_UNLOCKED;
    end else if (state_q == ST_LOCKED) begin
      idle_d = idle_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_UNLOCKED;
      rr_q     <= '0;
      owner_q  <= '0;
      idle_q   <= '0;
      rvalid_q <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      idle_q   <= idle_d;
      rvalid_q <= gnt;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  assign gnt_o      = gnt;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = ram_dout_i;
  assign lock_err_o = timeout;
  assign ram_addr_o = addr_d;
  assign ram_din_o  = din_d;
  assign ram_we_o   = |(gnt & we_i);
endmodule
